// File: rtl/disp_pkg.sv
// Shared types and constants for the 7-segment scan driver.
package disp_pkg;

  typedef enum logic {
    S_BLANK = 1'b0,
    S_SHOW  = 1'b1
  } scan_state_t;

  // Active-high pattern for a digit with every segment off
  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Active-high hex font, bit order {g,f,e,d,c,b,a}: 0-9, A b C d E F
  localparam logic [6:0] HEX7_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/disp_scan_mux_hex7seg.sv
// Combinational nibble to active-high 7-segment decoder.
module hex7seg
  import disp_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_c
);

  // Table lookup; output polarity is applied downstream
  assign seg_c = HEX7_TBL[nib];

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with inter-digit ghost blanking.
module disp_scan_mux
  import disp_pkg::*;
#(
  parameter int unsigned NDIG      = 4,
  parameter int unsigned GHOST_CYC = 2,
  parameter int unsigned SEG_ACT   = 0,
  parameter int unsigned AN_ACT    = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              scan_in,
  input  logic [4*NDIG-1:0] value,
  input  logic [NDIG-1:0]   dp_mask,
  input  logic              blank_lz,
  output logic [6:0]        seg,
  output logic              dp,
  output logic [NDIG-1:0]   an
);

  localparam int unsigned IW     = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned GW     = 4;
  localparam logic        SEG_ON = (SEG_ACT != 0);
  localparam logic        AN_ON  = (AN_ACT != 0);

  logic              scan_q;
  logic              step;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] val_q;
  logic [NDIG-1:0]   dpm_q;
  logic              blz_q;
  logic              armed;
  scan_state_t       state, state_nx;
  logic [GW-1:0]     gcnt, gcnt_nx;

  logic [3:0]        nib;
  logic              dp_sel;
  logic              lz_sel;
  logic [NDIG-1:0]   lz;
  logic              zero_run;
  logic [6:0]        seg_dec;

  logic [NDIG-1:0]   an1;
  logic [6:0]        seg1;
  logic              dp1;

  assign step = scan_in & ~scan_q;

  // Edge detect, digit index, snapshot and FSM state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q <= 1'b0;
      idx    <= '0;
      val_q  <= '0;
      dpm_q  <= '0;
      blz_q  <= 1'b0;
      armed  <= 1'b0;
      state  <= S_BLANK;
      gcnt   <= '0;
    end else begin
      scan_q <= scan_in;
      state  <= state_nx;
      gcnt   <= gcnt_nx;
      if (step) begin
        idx   <= (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);
        val_q <= value;
        dpm_q <= dp_mask;
        blz_q <= blank_lz;
        armed <= 1'b1;
      end
    end
  end

  // Next-state logic; armed keeps the display dark until the first scan step after reset
  always_comb begin
    state_nx = state;
    gcnt_nx  = gcnt;
    if (step) begin
      state_nx = (GHOST_CYC == 0) ? S_SHOW : S_BLANK;
      gcnt_nx  = '0;
    end else begin
      case (state)
        S_BLANK: begin
          if (armed) begin
            if ((GHOST_CYC == 0) || (gcnt == GW'(GHOST_CYC - 1))) begin
              state_nx = S_SHOW;
            end else begin
              gcnt_nx = gcnt + GW'(1);
            end
          end
        end
        S_SHOW:  state_nx = S_SHOW;
        default: state_nx = S_BLANK;
      endcase
    end
  end

  // Leading-zero mask: digit i blanks when it and every digit above it are zero
  always_comb begin
    zero_run = 1'b1;
    lz       = '0;
    for (int i = NDIG - 1; i >= 0; i--) begin
      zero_run = zero_run & (val_q[4*i +: 4] == 4'h0);
      lz[i]    = blz_q & (i > 0) & zero_run;
    end
  end

  // Select nibble, decimal point and blank flag of the current digit
  always_comb begin
    nib    = 4'h0;
    dp_sel = 1'b0;
    lz_sel = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (idx == IW'(i)) begin
        nib    = val_q[4*i +: 4];
        dp_sel = dpm_q[i];
        lz_sel = lz[i];
      end
    end
  end

  hex7seg u_hex7seg (
    .nib   (nib),
    .seg_c (seg_dec)
  );

  // Active-high display stage derived from the FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      an1  <= '0;
      seg1 <= SEG_BLANK;
      dp1  <= 1'b0;
    end else if (state == S_SHOW) begin
      an1  <= NDIG'(1) << idx;
      seg1 <= lz_sel ? SEG_BLANK : seg_dec;
      dp1  <= dp_sel;
    end else begin
      an1  <= '0;
      seg1 <= SEG_BLANK;
      dp1  <= 1'b0;
    end
  end

  // Output register applying pad polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      an  <= {NDIG{~AN_ON}};
      seg <= {7{~SEG_ON}};
      dp  <= ~SEG_ON;
    end else begin
      an  <= AN_ON ? an1 : ~an1;
      seg <= SEG_ON ? seg1 : ~seg1;
      dp  <= SEG_ON ? dp1 : ~dp1;
    end
  end

endmodule

// File: tb/tb_disp_scan_mux.sv
// Scoreboard bench for disp_scan_mux (GHOST_CYC=2 main instance, GHOST_CYC=0 latency instance).
module tb_disp_scan_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scan_in = 1'b0;
  logic [15:0] value = 16'h1234;
  logic [3:0]  dp_mask = 4'b0000;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg, seg0;
  logic        dp, dp0;
  logic [3:0]  an, an0;

  int tests = 0;
  int fails = 0;
  int tb_idx = 0;
  logic [11:0] exp_q [$];

  logic [6:0] hex_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  always #5 clk = ~clk;

  disp_scan_mux #(.NDIG(4), .GHOST_CYC(2), .SEG_ACT(0), .AN_ACT(0)) dut (
    .clk(clk), .rst(rst), .scan_in(scan_in), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg), .dp(dp), .an(an)
  );

  disp_scan_mux #(.NDIG(4), .GHOST_CYC(0), .SEG_ACT(0), .AN_ACT(0)) dut0 (
    .clk(clk), .rst(rst), .scan_in(scan_in), .value(value), .dp_mask(dp_mask),
    .blank_lz(blank_lz), .seg(seg0), .dp(dp0), .an(an0)
  );

  // Expected {an, seg, dp} at the pins (active-low) for digit d
  function automatic logic [11:0] model(input int d, input logic [15:0] v,
                                        input logic [3:0] m, input logic b);
    logic [3:0] nb;
    logic       zero;
    logic [6:0] s;
    logic [3:0] a;
    nb   = v[4*d +: 4];
    zero = 1'b1;
    for (int j = d; j < 4; j++) if (v[4*j +: 4] != 4'h0) zero = 1'b0;
    s    = (b && d > 0 && zero) ? 7'h00 : hex_tbl[nb];
    a    = 4'hF;
    a[d] = 1'b0;
    return {a, ~s, ~m[d]};
  endfunction

  task automatic check(input bit ok, input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  // One scan period of 8 clocks; also checks GHOST_CYC=0 latency and optional snapshot hold
  task automatic slot(input bit do_mid, input logic [15:0] mid_val);
    logic [11:0] e;
    logic [3:0]  old0;
    tb_idx = (tb_idx == 3) ? 0 : tb_idx + 1;
    e = model(tb_idx, value, dp_mask, blank_lz);
    exp_q.push_back(e);
    old0 = an0;
    scan_in = 1'b1;
    @(posedge clk); #1;
    check(an0 == old0, "g0_hold_e0", 32'(an0), 32'(old0));
    @(posedge clk); #1;
    check(an0 == old0, "g0_hold_e1", 32'(an0), 32'(old0));
    @(posedge clk); #1;
    check({an0, seg0, dp0} == e, "g0_show_e2", 32'({an0, seg0, dp0}), 32'(e));
    @(posedge clk); #1;
    scan_in = 1'b0;
    @(posedge clk); #1;
    if (do_mid) value = mid_val;
    @(posedge clk); #1;
    @(posedge clk); #1;
    if (do_mid) check(seg == e[7:1], "snapshot_hold", 32'(seg), 32'(e[7:1]));
    @(posedge clk); #1;
  endtask

  // Monitor: pops an expectation whenever a new digit appears, checks blanking between digits
  bit         first_after_rst = 1'b1;
  int         blank_run = 0;
  logic [3:0] prev_an = 4'hF;
  always @(negedge clk) begin
    logic [11:0] e;
    int zeros;
    if (rst) begin
      first_after_rst = 1'b1;
      blank_run = 0;
      prev_an = 4'hF;
    end else begin
      zeros = 0;
      for (int k = 0; k < 4; k++) if (!an[k]) zeros++;
      check(zeros <= 1, "onehot", 32'(an), 32'hE);
      if (an == 4'hF) begin
        blank_run++;
        check(seg == 7'h7F && dp == 1'b1, "blank_outputs", 32'({seg, dp}), 32'hFF);
      end else if (prev_an == 4'hF) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_digit", 32'({an, seg, dp}), 32'h0);
        end else begin
          e = exp_q.pop_front();
          check({an, seg, dp} == e, "digit", 32'({an, seg, dp}), 32'(e));
        end
        if (!first_after_rst) check(blank_run == 2, "ghost_len", 32'(blank_run), 32'd2);
        first_after_rst = 1'b0;
        blank_run = 0;
      end
      prev_an = an;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held while scan_in toggles
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      scan_in = ~scan_in;
      check(an == 4'hF && seg == 7'h7F && dp == 1'b1, "reset_state", 32'({an, seg, dp}), 32'hFFF);
      check(an0 == 4'hF, "reset_state_g0", 32'(an0), 32'hF);
    end
    scan_in = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Three full rotations of 1234
    for (int s = 0; s < 12; s++) slot(1'b0, 16'h0);

    // Leading-zero blanking on, then off
    value = 16'h0050; dp_mask = 4'b0100; blank_lz = 1'b1;
    for (int s = 0; s < 4; s++) slot(1'b0, 16'h0);
    blank_lz = 1'b0;
    for (int s = 0; s < 4; s++) slot(1'b0, 16'h0);

    // Snapshot: value change mid-slot must not reach the pins
    value = 16'h1234; dp_mask = 4'b0000;
    slot(1'b1, 16'hFFFF);

    // Mid-scan reset while showing a digit
    value = 16'h1234;
    rst = 1'b1;
    @(posedge clk); #1;
    check(an == 4'hF && seg == 7'h7F && dp == 1'b1, "midrst_g2", 32'({an, seg, dp}), 32'hFFF);
    check(an0 == 4'hF && seg0 == 7'h7F && dp0 == 1'b1, "midrst_g0", 32'({an0, seg0, dp0}), 32'hFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    tb_idx = 0;
    @(posedge clk); #1;
    slot(1'b0, 16'h0);
    slot(1'b0, 16'h0);

    repeat (8) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
